logicnet_input_quantizer: RTL

Streaming front end for the LogicNets classifier. It accepts raw unsigned feature words one per beat, quantizes each one against shared ascending thresholds, and packs the codes into the full input vector. It then presents that vector on a registered valid/ready output. It sits directly upstream of layer 0: bits of `m_data` fan out to the layer-0 neuron LUTs, for example a 4-bit neuron input taken from two adjacent 2-bit codes.

---
 rtl/logicnet_input_quantizer_if.sv | 25 ++
 rtl/logicnet_input_quantizer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/logicnet_input_quantizer_if.sv
// Feature-stream input / packed-sample output bundle
// for logicnet_input_quantizer.
interface logicnet_input_quantizer_if #(
  parameter int FEAT_W = 16,
  parameter int OUT_W  = 16
);
  logic              s_valid;
  logic              s_ready;
  logic [FEAT_W-1:0] s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [OUT_W-1:0]  m_data;
  logic              err;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, err
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, err
  );
endinterface

// File: rtl/logicnet_input_quantizer.sv
// Threshold-quantizes raw features and packs one sample per frame.
// Optional LOGICNET_INPUT_STATS_EN adds sample/drop counters.
module logicnet_input_quantizer #(
  parameter int NUM_FEATURES = 8,
  parameter int FEAT_W       = 16,
  parameter int Q_W          = 2,
  parameter logic [((1<<Q_W)-1)*FEAT_W-1:0] THRESH =
    {16'hC000, 16'h8000, 16'h4000}
) (
  input  logic clk,
  input  logic rst_n,
`ifdef LOGICNET_INPUT_STATS_EN
  output logic [15:0] sample_cnt,
  output logic [15:0] drop_cnt,
`endif
  logicnet_input_quantizer_if.slave io
);
  localparam int N_TH  = (1 << Q_W) - 1;
  localparam int OUT_W = NUM_FEATURES * Q_W;
  localparam int IDX_W =
    (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_FEATURES - 1);

  typedef enum logic {COLLECT, RESYNC} state_t;

  state_t           state, state_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  logic [OUT_W-1:0] asm_q, asm_nx;
  logic [OUT_W-1:0] out_nx;
  logic [Q_W-1:0]   code;
  logic             m_valid_nx;
  logic             err_nx;
  logic             load;
  logic             at_last;
  logic             fire;

  always_comb begin
    code = '0;
    for (int k = 0; k < N_TH; k++) begin
      if (io.s_data >= THRESH[k*FEAT_W +: FEAT_W])
        code = code + Q_W'(1);
    end
  end

  assign at_last = (idx == LAST_IDX);
  // Only the completing beat needs the output register.
  assign io.s_ready = !(state == COLLECT && at_last &&
                        io.m_valid && !io.m_ready);
  assign fire = io.s_valid && io.s_ready;

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    asm_nx     = asm_q;
    out_nx     = io.m_data;
    err_nx     = 1'b0;
    load       = 1'b0;
    m_valid_nx = io.m_valid && !io.m_ready;
    for (int i = 0; i < NUM_FEATURES; i++) begin
      if (fire && state == COLLECT && idx == IDX_W'(i))
        asm_nx[i*Q_W +: Q_W] = code;
    end
    if (fire) begin
      unique case (state)
        COLLECT: begin
          unique case (1'b1)
            !at_last && !io.s_last:
              idx_nx = idx + IDX_W'(1);
            !at_last && io.s_last: begin
              err_nx = 1'b1;
              idx_nx = '0;
            end
            at_last && io.s_last: begin
              load   = 1'b1;
              out_nx = asm_nx;
              idx_nx = '0;
            end
            default: begin
              err_nx   = 1'b1;
              idx_nx   = '0;
              state_nx = RESYNC;
            end
          endcase
        end
        RESYNC: begin
          if (io.s_last)
            state_nx = COLLECT;
        end
        default: state_nx = COLLECT;
      endcase
    end
    if (load)
      m_valid_nx = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= COLLECT;
      idx        <= '0;
      asm_q      <= '0;
      io.m_data  <= '0;
      io.m_valid <= 1'b0;
      io.err     <= 1'b0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      asm_q      <= asm_nx;
      io.m_data  <= out_nx;
      io.m_valid <= m_valid_nx;
      io.err     <= err_nx;
    end
  end

`ifdef LOGICNET_INPUT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (load && sample_cnt != 16'hFFFF)
        sample_cnt <= sample_cnt + 16'd1;
      if (err_nx && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif
endmodule
